// File: rtl/des_pkg.sv
// des_pkg -- shared constants for the DES key schedule.
//   PC1      : 56-entry PC-1 table (DES bit numbers, bit 1 = key MSB)
//   PC2      : 48-entry PC-2 table (bit numbers into C||D, bit 1 = C MSB)
//   SHIFTS   : per-round left-shift amounts, index = round - 1
//   ROUNDS   : number of DES rounds
//   state_t  : key-schedule FSM states
//   rotl28 / rotr28 : 28-bit rotate by 1 or 2 of a C or D half
package des_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// des_pc2_perm -- combinational PC-2 compression permutation.
//   cd     : C||D, 56 bits; DES bit b sits at index 56-b (bit 1 = MSB)
//   subkey : 48-bit round subkey; DES bit b sits at index 48-b
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign subkey[47-g] = cd[56-PC2[g]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule -- streams the 16 DES round subkeys of a key.
//   clk, rst (sync, active high)
//   key_in       : 64-bit key, DES bit 1 = key_in[63], parity bits 8,16,..,64
//   start/decrypt: job request (sampled in IDLE), decrypt reverses order
//   subkey_out/subkey_valid/subkey_ready : valid/ready subkey stream
//   round_idx    : DES round - 1 of subkey_out
//   busy, done   : job in progress / one-cycle completion pulse
//   parity_err   : odd-parity violation on the job key
// Optional: define DES_KEY_PARITY_CHK_EN to build the key parity checker;
// otherwise parity_err is tied low.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        start,
  input  logic        decrypt,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  state_t      state, state_nxt;
  logic [55:0] pc1_key, cd;
  logic [3:0]  cnt;
  logic        dec, xfer, last, accept;

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_key[55-g] = key_in[64-PC1[g]];
  end

  assign accept       = (state == S_IDLE) && start;
  assign subkey_valid = (state == S_RUN);
  assign busy         = (state == S_RUN);
  assign done         = (state == S_DONE);
  assign xfer         = subkey_valid && subkey_ready;
  assign last         = (cnt == 4'(ROUNDS-1));
  assign round_idx    = dec ? 4'(ROUNDS-1) - cnt : cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (xfer && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // cd always holds the C/D pair whose PC-2 is the subkey on the output.
  // Encrypt preloads the round-1 rotation; decrypt starts from C0D0, which
  // equals C16D16 since the shifts sum to 28, and then walks backwards by
  // undoing the shift of the round currently shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd  <= '0;
      cnt <= '0;
      dec <= 1'b0;
    end else if (accept) begin
      dec <= decrypt;
      cnt <= '0;
      cd  <= decrypt ? pc1_key
                     : {rotl28(pc1_key[55:28], 2'd1), rotl28(pc1_key[27:0], 2'd1)};
    end else if (xfer) begin
      cnt <= cnt + 4'd1;
      if (!last) begin
        if (dec) cd <= {rotr28(cd[55:28], SHIFTS[round_idx]),
                        rotr28(cd[27:0],  SHIFTS[round_idx])};
        else     cd <= {rotl28(cd[55:28], SHIFTS[round_idx + 4'd1]),
                        rotl28(cd[27:0],  SHIFTS[round_idx + 4'd1])};
      end
    end
  end

  des_pc2_perm u_pc2 (
    .cd     (cd),
    .subkey (subkey_out)
  );

`ifdef DES_KEY_PARITY_CHK_EN
  logic [7:0] byte_odd;
  for (genvar g = 0; g < 8; g++) begin : g_par
    assign byte_odd[g] = ^key_in[8*g +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst)         parity_err <= 1'b0;
    else if (accept) parity_err <= ~&byte_odd;
  end
`else
  // Parity bits are dropped by PC-1 and not otherwise needed.
  logic unused_par_bits;
  assign unused_par_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};
  assign parity_err = 1'b0;
`endif

endmodule
